// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Upper bounds for the generic helpers; instantiations must stay within them.
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxLanes     = 64;
  localparam int unsigned IdxWidth     = $clog2(MaxDataWidth);

  // Number of set bits in a lane mask.
  function automatic int unsigned popcount(input logic [MaxLanes-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Compacts the selected lanes (lowest lane at bit 0) so the serializer can always
  // shift out from bit 0. For MSB-first the compacted bits are mirrored, which puts
  // the MSB of the highest selected lane at bit 0.
  function automatic logic [MaxDataWidth-1:0] pack_lanes(
    input logic [MaxLanes-1:0]     mask,
    input logic                    msb_first,
    input logic [MaxDataWidth-1:0] data,
    input int unsigned             lane_width,
    input int unsigned             num_lanes
  );
    logic [MaxDataWidth-1:0] packed_w;
    logic [MaxDataWidth-1:0] result;
    int unsigned             word_len;
    packed_w = '0;
    result   = '0;
    word_len = 0;
    for (int unsigned l = 0; l < MaxLanes; l++) begin
      if (l < num_lanes && mask[l]) begin
        for (int unsigned b = 0; b < MaxDataWidth; b++) begin
          if (b < lane_width && (word_len + b) < MaxDataWidth &&
              (l * lane_width + b) < MaxDataWidth) begin
            packed_w[IdxWidth'(word_len + b)] = data[IdxWidth'(l * lane_width + b)];
          end
        end
        word_len += lane_width;
      end
    end
    if (msb_first) begin
      for (int unsigned i = 0; i < MaxDataWidth; i++) begin
        if (i < word_len) result[IdxWidth'(i)] = packed_w[IdxWidth'(word_len - 1 - i)];
      end
    end else begin
      result = packed_w;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_fifo.sv
// Synchronous FIFO; full/empty derived from the occupancy count.
module piso_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CountWidth = $clog2(DEPTH + 1),
  localparam int unsigned PtrWidth   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic                push_ok, pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full    = (count == CountWidth'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Buffers MRAM words and streams their selected lanes as a framed serial bitstream.
module piso_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned NUM_LANES  = DATA_WIDTH / LANE_WIDTH,
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_LANES-1:0]  lane_mask,
  input  logic                  msb_first,
  output logic                  ser_data,
  output logic                  ser_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy,
  output logic [CountWidth-1:0] fifo_count,
  output logic                  mask_err
);

  import piso_pkg::*;

  localparam int unsigned EntryWidth  = NUM_LANES + 1 + DATA_WIDTH;
  localparam int unsigned BitCntWidth = $clog2(DATA_WIDTH + 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [BitCntWidth-1:0]  bit_cnt_q;
  logic                    first_q;

  logic                    accept, push, pop, fifo_full, fifo_empty, last_bit;
  logic [EntryWidth-1:0]   wr_entry, rd_entry;
  logic [NUM_LANES-1:0]    rd_mask;
  logic                    rd_msb_first;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [MaxLanes-1:0]     mask_ext;
  logic [MaxDataWidth-1:0] data_ext, pack_full;
  logic [DATA_WIDTH-1:0]   pack_word;
  logic [BitCntWidth-1:0]  load_cnt;

  // Zero-mask words are accepted (handshake completes) but never stored.
  assign load_ready = ~fifo_full;
  assign accept     = en & load_valid & ~fifo_full;
  assign push       = accept & (|lane_mask);
  assign wr_entry   = {lane_mask, msb_first, data_in};

  assign last_bit = (bit_cnt_q == BitCntWidth'(1));
  assign pop      = en & ~fifo_empty & ((state_q == StIdle) | ((state_q == StShift) & last_bit));

  assign rd_mask      = rd_entry[EntryWidth-1 -: NUM_LANES];
  assign rd_msb_first = rd_entry[DATA_WIDTH];
  assign rd_data      = rd_entry[DATA_WIDTH-1:0];

  // Widen the popped entry to the helper functions' generic widths.
  always_comb begin
    mask_ext = '0;
    data_ext = '0;
    mask_ext[NUM_LANES-1:0]  = rd_mask;
    data_ext[DATA_WIDTH-1:0] = rd_data;
  end

  assign pack_full = pack_lanes(mask_ext, rd_msb_first, data_ext, LANE_WIDTH, NUM_LANES);
  assign pack_word = pack_full[DATA_WIDTH-1:0];
  assign load_cnt  = BitCntWidth'(popcount(mask_ext) * LANE_WIDTH);

  assign busy = ~fifo_empty | (state_q != StIdle);

  piso_fifo #(
    .WIDTH(EntryWidth),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer FSM: loads a packed word on pop, then shifts one bit per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      ser_data    <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      mask_err    <= 1'b0;
    end else if (!en) begin
      // Frozen: strobes drop, ser_data and all state hold.
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      mask_err    <= 1'b0;
    end else begin
      mask_err    <= accept & ~(|lane_mask);
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shreg_q   <= pack_word;
            bit_cnt_q <= load_cnt;
            first_q   <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          ser_data    <= shreg_q[0];
          ser_valid   <= 1'b1;
          frame_start <= first_q;
          frame_end   <= last_bit;
          shreg_q     <= shreg_q >> 1;
          bit_cnt_q   <= bit_cnt_q - BitCntWidth'(1);
          first_q     <= 1'b0;
          if (last_bit) begin
            // Reload on the last bit so the next frame follows with no gap.
            if (pop) begin
              shreg_q   <= pack_word;
              bit_cnt_q <= load_cnt;
              first_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
